// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - configuration, run control, serial input and status bundle
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             i_cfg_we;
    logic [PAT_W-1:0] i_cfg_pattern;
    logic             i_cfg_overlap;
    logic [CNT_W-1:0] i_cfg_target;
    logic [CNT_W-1:0] i_cfg_timeout;
    logic             i_start;
    logic             i_abort;
    logic             i_in;
    logic             i_in_valid;
    logic             o_out;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout;

    modport master (
        output i_cfg_we, i_cfg_pattern, i_cfg_overlap, i_cfg_target, i_cfg_timeout,
        output i_start, i_abort, i_in, i_in_valid,
        input  o_out, o_match_cnt, o_busy, o_done, o_timeout
    );

    modport slave (
        input  i_cfg_we, i_cfg_pattern, i_cfg_overlap, i_cfg_target, i_cfg_timeout,
        input  i_start, i_abort, i_in, i_in_valid,
        output o_out, o_match_cnt, o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run controller around a serial pattern-match engine
module seq_detect_ctrl #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    seq_detect_ctrl_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [PAT_W-1:0] r_pattern, w_pattern_next;
    logic             r_overlap, w_overlap_next;
    logic [CNT_W-1:0] r_target, w_target_next;
    logic [CNT_W-1:0] r_tmo_limit, w_tmo_limit_next;
    logic [PAT_W-1:0] r_hist, w_hist_next;
    logic [FILL_W-1:0] r_fill, w_fill_next;
    logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_next;
    logic [CNT_W-1:0] r_match_cnt, w_match_cnt_next;
    logic             r_out, w_out_next;
    logic             r_done, w_done_next;
    logic             r_timeout, w_timeout_next;

    logic [PAT_W-1:0]  w_hist_sh;
    logic [FILL_W-1:0] w_fill_sh;
    logic              w_hit;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  w_idle_inc;

    // Candidate values if the current bit is shifted in; the FSM decides whether to commit them.
    assign w_hist_sh  = {r_hist[PAT_W-2:0], bus.i_in};
    assign w_fill_sh  = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    assign w_hit      = bus.i_in_valid && (w_fill_sh == FILL_FULL) && (w_hist_sh == r_pattern);
    assign w_cnt_inc  = (&r_match_cnt) ? r_match_cnt : r_match_cnt + CNT_W'(1);
    assign w_idle_inc = (&r_idle_cnt) ? r_idle_cnt : r_idle_cnt + CNT_W'(1);

    always_comb begin
        w_state_next     = r_state;
        w_pattern_next   = r_pattern;
        w_overlap_next   = r_overlap;
        w_target_next    = r_target;
        w_tmo_limit_next = r_tmo_limit;
        w_hist_next      = r_hist;
        w_fill_next      = r_fill;
        w_idle_cnt_next  = r_idle_cnt;
        w_match_cnt_next = r_match_cnt;
        w_out_next       = 1'b0;
        w_done_next      = 1'b0;
        w_timeout_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_cfg_we) begin
                    w_pattern_next   = bus.i_cfg_pattern;
                    w_overlap_next   = bus.i_cfg_overlap;
                    w_target_next    = bus.i_cfg_target;
                    w_tmo_limit_next = bus.i_cfg_timeout;
                end
                if (bus.i_start) begin
                    w_match_cnt_next = '0;
                    w_hist_next      = '0;
                    w_fill_next      = '0;
                    w_idle_cnt_next  = '0;
                    w_state_next     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    if (bus.i_in_valid) begin
                        w_hist_next = w_hist_sh;
                        w_fill_next = (w_hit && !r_overlap) ? '0 : w_fill_sh;
                    end
                    // A hit clears the idle counter, so done always wins over timeout.
                    if (w_hit) begin
                        w_match_cnt_next = w_cnt_inc;
                        w_idle_cnt_next  = '0;
                        w_out_next       = 1'b1;
                        if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end else if (bus.i_in_valid) begin
                        w_idle_cnt_next = w_idle_inc;
                        if ((r_tmo_limit != '0) && (w_idle_inc == r_tmo_limit)) begin
                            w_timeout_next = 1'b1;
                            w_state_next   = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pattern   <= '0;
            r_overlap   <= 1'b1;
            r_target    <= '0;
            r_tmo_limit <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_idle_cnt  <= '0;
            r_match_cnt <= '0;
            r_out       <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pattern   <= w_pattern_next;
            r_overlap   <= w_overlap_next;
            r_target    <= w_target_next;
            r_tmo_limit <= w_tmo_limit_next;
            r_hist      <= w_hist_next;
            r_fill      <= w_fill_next;
            r_idle_cnt  <= w_idle_cnt_next;
            r_match_cnt <= w_match_cnt_next;
            r_out       <= w_out_next;
            r_done      <= w_done_next;
            r_timeout   <= w_timeout_next;
        end
    end

    assign bus.o_out       = r_out;
    assign bus.o_match_cnt = r_match_cnt;
    assign bus.o_busy      = (r_state == ST_RUN);
    assign bus.o_done      = r_done;
    assign bus.o_timeout   = r_timeout;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;
    localparam int PAT_W = 3;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [PAT_W-1:0] pat, input logic ov,
                             input logic [CNT_W-1:0] tgt, input logic [CNT_W-1:0] tmo);
        bus.i_cfg_pattern = pat;
        bus.i_cfg_overlap = ov;
        bus.i_cfg_target  = tgt;
        bus.i_cfg_timeout = tmo;
        bus.i_cfg_we      = 1'b1;
        tick();
        bus.i_cfg_we      = 1'b0;
    endtask

    task automatic start_run(input string tag);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check_eq({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
        check_eq({tag, "_cnt0"}, 32'(bus.o_match_cnt), 32'd0);
    endtask

    task automatic send_bit(input string tag, input logic b, input logic exp_out);
        bus.i_in       = b;
        bus.i_in_valid = 1'b1;
        tick();
        bus.i_in_valid = 1'b0;
        check_eq(tag, 32'(bus.o_out), 32'(exp_out));
    endtask

    task automatic abort_run();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.i_cfg_we = 1'b0; bus.i_cfg_pattern = '0; bus.i_cfg_overlap = 1'b0;
        bus.i_cfg_target = '0; bus.i_cfg_timeout = '0;
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_in = 1'b0; bus.i_in_valid = 1'b0;

        // T1 reset with random serial traffic
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.i_in = 1'($urandom_range(0, 1));
            bus.i_in_valid = 1'b1;
            tick();
        end
        bus.i_in_valid = 1'b0;
        rst = 1'b0;
        check_eq("t1_out", 32'(bus.o_out), 32'd0);
        check_eq("t1_done", 32'(bus.o_done), 32'd0);
        check_eq("t1_timeout", 32'(bus.o_timeout), 32'd0);
        check_eq("t1_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t1_cnt", 32'(bus.o_match_cnt), 32'd0);
        tick();

        // T2 overlapping 101
        configure(3'b101, 1'b1, 8'd0, 8'd0);
        start_run("t2");
        send_bit("t2_b1", 1'b1, 1'b0);
        send_bit("t2_b2", 1'b0, 1'b0);
        send_bit("t2_b3", 1'b1, 1'b1);
        send_bit("t2_b4", 1'b0, 1'b0);
        send_bit("t2_b5", 1'b1, 1'b1);
        check_eq("t2_cnt", 32'(bus.o_match_cnt), 32'd2);
        tick();
        check_eq("t2_nohit_idle_cycle", 32'(bus.o_out), 32'd0);
        abort_run();
        check_eq("t2_abort_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t2_cnt_hold", 32'(bus.o_match_cnt), 32'd2);
        abort_run();
        check_eq("idle_abort_cnt", 32'(bus.o_match_cnt), 32'd2);
        check_eq("idle_abort_busy", 32'(bus.o_busy), 32'd0);

        // T3 non-overlapping 101, then 1,0,1 appended
        configure(3'b101, 1'b0, 8'd0, 8'd0);
        start_run("t3");
        send_bit("t3_b1", 1'b1, 1'b0);
        send_bit("t3_b2", 1'b0, 1'b0);
        send_bit("t3_b3", 1'b1, 1'b1);
        send_bit("t3_b4", 1'b0, 1'b0);
        send_bit("t3_b5", 1'b1, 1'b0);
        check_eq("t3_cnt1", 32'(bus.o_match_cnt), 32'd1);
        send_bit("t3_b6", 1'b1, 1'b0);
        send_bit("t3_b7", 1'b0, 1'b0);
        send_bit("t3_b8", 1'b1, 1'b1);
        check_eq("t3_cnt2", 32'(bus.o_match_cnt), 32'd2);
        abort_run();

        // T4 target of two matches
        configure(3'b101, 1'b1, 8'd2, 8'd0);
        start_run("t4");
        send_bit("t4_b1", 1'b1, 1'b0);
        send_bit("t4_b2", 1'b0, 1'b0);
        send_bit("t4_b3", 1'b1, 1'b1);
        check_eq("t4_done_early", 32'(bus.o_done), 32'd0);
        send_bit("t4_b4", 1'b0, 1'b0);
        send_bit("t4_b5", 1'b1, 1'b1);
        check_eq("t4_done", 32'(bus.o_done), 32'd1);
        check_eq("t4_cnt", 32'(bus.o_match_cnt), 32'd2);
        tick();
        check_eq("t4_busy_low", 32'(bus.o_busy), 32'd0);
        check_eq("t4_done_pulse", 32'(bus.o_done), 32'd0);
        send_bit("t4_idle_b1", 1'b1, 1'b0);
        send_bit("t4_idle_b2", 1'b0, 1'b0);
        send_bit("t4_idle_b3", 1'b1, 1'b0);
        check_eq("t4_idle_cnt", 32'(bus.o_match_cnt), 32'd2);

        // T5 timeout after four unmatched bits
        configure(3'b101, 1'b1, 8'd0, 8'd4);
        start_run("t5");
        for (int i = 0; i < 3; i++) begin
            send_bit("t5_out", 1'b0, 1'b0);
            check_eq("t5_tmo_early", 32'(bus.o_timeout), 32'd0);
        end
        send_bit("t5_b4", 1'b0, 1'b0);
        check_eq("t5_timeout", 32'(bus.o_timeout), 32'd1);
        check_eq("t5_cnt", 32'(bus.o_match_cnt), 32'd0);
        tick();
        check_eq("t5_busy_low", 32'(bus.o_busy), 32'd0);
        check_eq("t5_tmo_pulse", 32'(bus.o_timeout), 32'd0);

        // T6a abort coinciding with the completing bit
        configure(3'b101, 1'b1, 8'd0, 8'd0);
        start_run("t6a");
        send_bit("t6a_b1", 1'b1, 1'b0);
        send_bit("t6a_b2", 1'b0, 1'b0);
        bus.i_abort = 1'b1;
        send_bit("t6a_b3_abort", 1'b1, 1'b0);
        bus.i_abort = 1'b0;
        check_eq("t6a_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t6a_cnt", 32'(bus.o_match_cnt), 32'd0);

        // T6b config writes during RUN are ignored
        start_run("t6b");
        configure(3'b111, 1'b0, 8'd1, 8'd1);
        check_eq("t6b_busy_cfg", 32'(bus.o_busy), 32'd1);
        send_bit("t6b_b1", 1'b1, 1'b0);
        send_bit("t6b_b2", 1'b0, 1'b0);
        send_bit("t6b_b3", 1'b1, 1'b1);
        check_eq("t6b_done", 32'(bus.o_done), 32'd0);
        check_eq("t6b_busy", 32'(bus.o_busy), 32'd1);
        check_eq("t6b_cnt", 32'(bus.o_match_cnt), 32'd1);

        // T6c reset mid-run, then run with reset config (pattern 000, overlap)
        rst = 1'b1;
        send_bit("t6c_rst_out", 1'b1, 1'b0);
        rst = 1'b0;
        check_eq("t6c_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t6c_cnt", 32'(bus.o_match_cnt), 32'd0);
        start_run("t6c");
        send_bit("t6c_b1", 1'b0, 1'b0);
        send_bit("t6c_b2", 1'b0, 1'b0);
        send_bit("t6c_b3", 1'b0, 1'b1);
        send_bit("t6c_b4", 1'b0, 1'b1);
        check_eq("t6c_cnt2", 32'(bus.o_match_cnt), 32'd2);
        check_eq("t6c_busy_run", 32'(bus.o_busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
